// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates fetch and data ports onto a 16-bit async SRAM,
//            splitting each 32-bit access into low and high halfword cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic [17:0] addr,
    inout  wire  [15:0] data,
    output logic        wre,
    output logic        oute,
    output logic        chip_en,
    output logic        hb_mask,
    output logic        lb_mask
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t      r_state;
    logic        r_last_d;
    logic        r_sel_d;
    logic        r_we;
    logic [15:0] r_wdata_hi;
    logic [1:0]  r_be_hi;
    logic [17:0] r_haddr;
    logic [15:0] r_lo;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_if_ack;
    logic        r_d_ack;
    logic        r_err;
    logic [17:0] r_addr;
    logic        r_wre;
    logic        r_oute;
    logic        r_cen;
    logic        r_hb;
    logic        r_lb;
    logic        r_oe;
    logic [15:0] r_dout;

    logic        w_grant_d;
    logic        w_any;
    logic [17:0] w_haddr;
    logic        w_misal;
    logic        w_wr;
    wire         w_unused = ^{if_addr[31:19], d_addr[31:19], if_addr[0], d_addr[0]};

    // With both requesting, FAIR hands the grant to whichever port lost last time.
    assign w_grant_d = d_req && (!if_req || (FAIR == 0) || !r_last_d);
    assign w_any     = if_req || d_req;
    assign w_haddr   = w_grant_d ? d_addr[18:1] : if_addr[18:1];
    assign w_misal   = w_grant_d ? (d_addr[1:0] != 2'b00) : (if_addr[1:0] != 2'b00);
    assign w_wr      = w_grant_d && d_we;

    assign data     = r_oe ? r_dout : 16'hzzzz;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_ack   = r_if_ack;
    assign d_ack    = r_d_ack;
    assign err      = r_err;
    assign addr     = r_addr;
    assign wre      = r_wre;
    assign oute     = r_oute;
    assign chip_en  = r_cen;
    assign hb_mask  = r_hb;
    assign lb_mask  = r_lb;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b0;
            r_sel_d    <= 1'b0;
            r_we       <= 1'b0;
            r_wdata_hi <= 16'h0;
            r_be_hi    <= 2'b00;
            r_haddr    <= 18'h0;
            r_lo       <= 16'h0;
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 18'h0;
            r_wre      <= 1'b1;
            r_oute     <= 1'b1;
            r_cen      <= 1'b1;
            r_hb       <= 1'b1;
            r_lb       <= 1'b1;
            r_oe       <= 1'b0;
            r_dout     <= 16'h0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel_d    <= w_grant_d;
                        r_last_d   <= w_grant_d;
                        r_we       <= w_wr;
                        r_wdata_hi <= d_wdata[31:16];
                        r_be_hi    <= d_be[3:2];
                        r_haddr    <= w_haddr;
                        if (w_misal) begin
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                            if (w_grant_d) begin
                                r_d_ack   <= 1'b1;
                                r_d_rdata <= 32'h0;
                            end else begin
                                r_if_ack   <= 1'b1;
                                r_if_rdata <= 32'h0;
                            end
                        end else begin
                            r_state <= S_LO;
                            r_addr  <= w_haddr;
                            r_cen   <= 1'b0;
                            r_wre   <= !w_wr;
                            r_oute  <= w_wr;
                            r_oe    <= w_wr;
                            r_dout  <= d_wdata[15:0];
                            r_lb    <= w_wr ? !d_be[0] : 1'b0;
                            r_hb    <= w_wr ? !d_be[1] : 1'b0;
                        end
                    end
                end
                S_LO: begin
                    r_state <= S_HI;
                    r_lo    <= data;
                    r_addr  <= r_haddr + 18'd1;
                    if (r_we) begin
                        r_dout <= r_wdata_hi;
                        r_lb   <= !r_be_hi[0];
                        r_hb   <= !r_be_hi[1];
                    end
                end
                S_HI: begin
                    r_state <= S_DONE;
                    if (r_sel_d) begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= r_we ? 32'h0 : {data, r_lo};
                    end else begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= {data, r_lo};
                    end
                    r_addr <= 18'h0;
                    r_cen  <= 1'b1;
                    r_wre  <= 1'b1;
                    r_oute <= 1'b1;
                    r_hb   <= 1'b1;
                    r_lb   <= 1'b1;
                    r_oe   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a halfword SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;

    logic [31:0] if_rdata, d_rdata;
    logic        if_ack, d_ack, err;
    logic [17:0] addr;
    tri   [15:0] data;
    logic        wre, oute, chip_en, hb_mask, lb_mask;

    logic [31:0] if_rdata0, d_rdata0;
    logic        if_ack0, d_ack0, err0;
    logic [17:0] addr0;
    tri   [15:0] data0;
    logic        wre0, oute0, chip_en0, hb_mask0, lb_mask0;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:262143];

    always #5 clock = ~clock;

    mem_arbiter #(.FAIR(1)) u_dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .addr(addr), .data(data), .wre(wre), .oute(oute), .chip_en(chip_en),
        .hb_mask(hb_mask), .lb_mask(lb_mask)
    );

    mem_arbiter #(.FAIR(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata0), .if_ack(if_ack0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata0), .d_ack(d_ack0), .err(err0),
        .addr(addr0), .data(data0), .wre(wre0), .oute(oute0), .chip_en(chip_en0),
        .hb_mask(hb_mask0), .lb_mask(lb_mask0)
    );

    // Asynchronous SRAM: reads drive the bus, writes commit per byte lane on the clock edge.
    assign data = (!chip_en && !oute && wre) ? mem[addr] : 16'hzzzz;

    always @(posedge clock) begin
        if (!chip_en && !wre) begin
            if (!lb_mask) mem[addr][7:0]  <= data[7:0];
            if (!hb_mask) mem[addr][15:8] <= data[15:8];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        mem[18'h10] = 16'h5678; mem[18'h11] = 16'h1234;
        mem[18'h20] = 16'h1122; mem[18'h21] = 16'h3344;
        mem[18'h40] = 16'h9ABC; mem[18'h41] = 16'hEF01;
        mem[18'h3FFFE] = 16'hBEEF; mem[18'h3FFFF] = 16'hDEAD;
        tick(); tick();

        chk("rst_if_ack", {31'b0, if_ack}, 32'h0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_ctl", {27'b0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h1F);
        chk("rst_addr", {14'b0, addr}, 32'h0);
        reset = 1'b0;

        // Aligned fetch read
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        chk("rd_lo_addr", {14'b0, addr}, 32'h10);
        chk("rd_lo_ctl", {27'b0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h04);
        chk("rd_lo_ack", {30'b0, if_ack, d_ack}, 32'h0);
        tick();
        chk("rd_hi_addr", {14'b0, addr}, 32'h11);
        chk("rd_hi_oute", {31'b0, oute}, 32'h0);
        tick();
        chk("rd_done_ack", {29'b0, if_ack, d_ack, err}, 32'h4);
        chk("rd_done_data", if_rdata, 32'h12345678);
        chk("rd_done_cen", {31'b0, chip_en}, 32'h1);
        if_req = 1'b0;
        tick();
        chk("rd_idle_ack", {31'b0, if_ack}, 32'h0);
        chk("rd_hold", if_rdata, 32'h12345678);

        // Partial write with byte enables 0110
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hAABBCCDD; d_be = 4'b0110;
        tick();
        chk("wr_lo_ctl", {27'b0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h09);
        chk("wr_lo_addr", {14'b0, addr}, 32'h20);
        tick();
        chk("wr_hi_ctl", {27'b0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h0A);
        chk("wr_hi_addr", {14'b0, addr}, 32'h21);
        tick();
        chk("wr_done_ack", {29'b0, if_ack, d_ack, err}, 32'h2);
        chk("wr_done_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wr_mem_lo", {16'b0, mem[18'h20]}, 32'hCC22);
        chk("wr_mem_hi", {16'b0, mem[18'h21]}, 32'h33BB);

        // Top of memory; upper address bits ignored
        if_req = 1'b1; if_addr = 32'hFFF7FFFC;
        tick();
        chk("top_lo_addr", {14'b0, addr}, 32'h3FFFE);
        tick();
        chk("top_hi_addr", {14'b0, addr}, 32'h3FFFF);
        tick();
        chk("top_data", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();

        // Misaligned fetch
        if_req = 1'b1; if_addr = 32'h3FFFE;
        tick();
        chk("mis_if_ack", {29'b0, if_ack, d_ack, err}, 32'h5);
        chk("mis_if_rdata", if_rdata, 32'h0);
        chk("mis_if_cen", {31'b0, chip_en}, 32'h1);
        if_req = 1'b0;
        tick();

        // Reset during the high half aborts, then the held request completes
        if_req = 1'b1; if_addr = 32'h20;
        tick(); tick();
        chk("abt_hi_addr", {14'b0, addr}, 32'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abt_ack", {29'b0, if_ack, d_ack, err}, 32'h0);
        chk("abt_ctl", {27'b0, chip_en, oute, wre, hb_mask, lb_mask}, 32'h1F);
        chk("abt_addr", {14'b0, addr}, 32'h0);
        chk("abt_rdata", if_rdata, 32'h0);
        tick(); tick();
        chk("abt_pre_ack", {31'b0, if_ack}, 32'h0);
        tick();
        chk("abt_retry_ack", {31'b0, if_ack}, 32'h1);
        chk("abt_retry_data", if_rdata, 32'h12345678);

        // Both ports held: FAIR=1 alternates starting with data, FAIR=0 always data
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); tick(); tick();
            chk($sformatf("fair_d_ack%0d", i), {31'b0, d_ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("fair_if_ack%0d", i), {31'b0, if_ack}, (i % 2 == 0) ? 32'h0 : 32'h1);
            chk($sformatf("prio_acks%0d", i), {30'b0, d_ack0, if_ack0}, 32'h2);
            if (i % 2 == 0) chk($sformatf("fair_d_data%0d", i), d_rdata, 32'hEF019ABC);
            else            chk($sformatf("fair_if_data%0d", i), if_rdata, 32'h12345678);
            tick();
            chk($sformatf("fair_gap%0d", i), {30'b0, if_ack, d_ack}, 32'h0);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick(); tick();

        // Misaligned data access
        d_req = 1'b1; d_addr = 32'h42;
        chk("mis_d_cen0", {31'b0, chip_en}, 32'h1);
        tick();
        chk("mis_d_ack", {29'b0, if_ack, d_ack, err}, 32'h3);
        chk("mis_d_rdata", d_rdata, 32'h0);
        chk("mis_d_cen", {31'b0, chip_en}, 32'h1);
        d_req = 1'b0;
        tick();
        chk("mis_d_clear", {29'b0, if_ack, d_ack, err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
